// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch-PC generator.
package pc_pkg;
    typedef enum logic [1:0] {
        JUMP = 2'd0,
        CALL = 2'd1,
        RET  = 2'd2
    } redirect_kind_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } pc_state_t;

    localparam int unsigned DEF_XLEN       = 32;
    localparam logic [31:0] DEF_RESET_VEC  = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC   = 32'h0000_0100;
    localparam int unsigned DEF_INC        = 4;
    localparam int unsigned DEF_ALIGN_BITS = 2;
    localparam int unsigned DEF_RAS_DEPTH  = 4;
endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle: stall/redirect/trap in, fetch request and status pulses out.
interface pc_gen_if #(parameter int unsigned XLEN = 32);
    logic            stall_i;
    logic            imem_ready_i;
    logic            imem_req_o;
    logic [XLEN-1:0] pc_o;
    logic            redirect_valid_i;
    logic [1:0]      redirect_kind_i;
    logic [XLEN-1:0] redirect_addr_i;
    logic [XLEN-1:0] redirect_link_i;
    logic            trap_i;
    logic            misalign_o;
    logic [XLEN-1:0] badaddr_o;
    logic            ras_miss_o;

    modport master (
        input  stall_i, imem_ready_i, redirect_valid_i, redirect_kind_i,
               redirect_addr_i, redirect_link_i, trap_i,
        output imem_req_o, pc_o, misalign_o, badaddr_o, ras_miss_o
    );

    modport slave (
        output stall_i, imem_ready_i, redirect_valid_i, redirect_kind_i,
               redirect_addr_i, redirect_link_i, trap_i,
        input  imem_req_o, pc_o, misalign_o, badaddr_o, ras_miss_o
    );
endinterface

// File: rtl/return_addr_stack.sv
// Circular return-address LIFO; a push when full silently overwrites the oldest entry.
// Top/empty are combinational from state; push and pop are never requested together.
module return_addr_stack #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] top,
    output logic            empty
);
    localparam int unsigned PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW:0]     count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (count != (PW+1)'(RAS_DEPTH)) begin
                count <= count + (PW+1)'(1);
            end
        end else if (pop && !empty) begin
            ptr   <= ptr - PW'(1);
            count <= count - (PW+1)'(1);
        end
    end

    // Entry storage needs no reset: top is only consumed when count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= data;
        end
    end

    assign top   = mem[ptr - PW'(1)];
    assign empty = (count == '0);
endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: reset vector, stall, jump/call/return redirects, traps, misalign trapping.
// Redirect/trap take effect on pc_o one cycle later; req depends only on state and stall.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN       = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(DEF_TRAP_VEC),
    parameter int unsigned     INC        = DEF_INC,
    parameter int unsigned     ALIGN_BITS = DEF_ALIGN_BITS,
    parameter int unsigned     RAS_DEPTH  = DEF_RAS_DEPTH
) (
    input  logic     clk,
    input  logic     rst_n,
    pc_gen_if.master bus
);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    pc_state_t       state, state_nxt;
    logic [XLEN-1:0] pc_q, pc_nxt, badaddr_q, ras_top, target;
    logic            misalign_q, ras_miss_q, ras_empty, ras_push, ras_pop;
    logic            is_call, is_ret, trap_take, redir_take, misaligned, req;

    assign is_call    = (bus.redirect_kind_i == CALL);
    assign is_ret     = (bus.redirect_kind_i == RET);
    // RET resolves to the stack top when one exists, else to the supplied fallback.
    assign target     = (is_ret && !ras_empty) ? ras_top : bus.redirect_addr_i;
    assign trap_take  = bus.trap_i && (state != BOOT);
    assign redir_take = bus.redirect_valid_i && (state == RUN) && !bus.trap_i;
    assign misaligned = redir_take && ((target & ALIGN_MASK) != '0);
    assign ras_push   = redir_take && !misaligned && is_call;
    assign ras_pop    = redir_take && !misaligned && is_ret && !ras_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (trap_take || misaligned) state_nxt = FLUSH;
            FLUSH:   if (!trap_take) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        req = (state == RUN) && !bus.stall_i;
    end

    always_comb begin
        pc_nxt = pc_q;
        if (trap_take || misaligned) begin
            pc_nxt = TRAP_VEC;
        end else if (redir_take) begin
            pc_nxt = target;
        end else if (req && bus.imem_ready_i) begin
            pc_nxt = pc_q + XLEN'(INC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
            badaddr_q  <= '0;
            ras_miss_q <= 1'b0;
        end else begin
            pc_q       <= pc_nxt;
            misalign_q <= misaligned;
            ras_miss_q <= redir_take && !misaligned && is_ret && ras_empty;
            if (misaligned) begin
                badaddr_q <= target;
            end
        end
    end

    return_addr_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ras_push),
        .pop   (ras_pop),
        .data  (bus.redirect_link_i),
        .top   (ras_top),
        .empty (ras_empty)
    );

    assign bus.imem_req_o = req;
    assign bus.pc_o       = pc_q;
    assign bus.misalign_o = misalign_q;
    assign bus.badaddr_o  = badaddr_q;
    assign bus.ras_miss_o = ras_miss_q;
endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_pc_gen;
    localparam logic [31:0] TRAP  = 32'h100;
    localparam int          DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pc_gen_if #(.XLEN(32)) bus ();

    pc_gen #(
        .XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100),
        .INC(4), .ALIGN_BITS(2), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef enum {M_BOOT, M_RUN, M_FLUSH} mode_t;
    mode_t       m_mode;
    logic [31:0] m_pc, m_bad;
    bit          m_mis, m_miss;
    logic [31:0] m_ras [$];

    task automatic drive(bit stall, bit ready, bit rv, logic [1:0] kind,
                         logic [31:0] addr, logic [31:0] link, bit trap);
        bus.stall_i          = stall;
        bus.imem_ready_i     = ready;
        bus.redirect_valid_i = rv;
        bus.redirect_kind_i  = kind;
        bus.redirect_addr_i  = addr;
        bus.redirect_link_i  = link;
        bus.trap_i           = trap;
    endtask

    task automatic idle();
        drive(0, 1, 0, 2'd0, 32'h0, 32'h0, 0);
    endtask

    task automatic model_reset();
        m_mode = M_BOOT; m_pc = 32'h0; m_bad = 32'h0; m_mis = 0; m_miss = 0;
        m_ras.delete();
    endtask

    // Advance the model using the inputs currently applied, then clock the DUT.
    task automatic step();
        logic [31:0] tgt;
        bit          fetch;
        fetch  = (m_mode == M_RUN) && !bus.stall_i && bus.imem_ready_i;
        m_mis  = 0;
        m_miss = 0;
        case (m_mode)
            M_BOOT: m_mode = M_RUN;
            M_FLUSH: begin
                if (bus.trap_i) m_pc = TRAP;
                else m_mode = M_RUN;
            end
            default: begin
                if (bus.trap_i) begin
                    m_pc = TRAP; m_mode = M_FLUSH;
                end else if (bus.redirect_valid_i) begin
                    tgt = (bus.redirect_kind_i == 2'd2 && m_ras.size() > 0) ? m_ras[$] : bus.redirect_addr_i;
                    if (tgt[1:0] != 2'b00) begin
                        m_pc = TRAP; m_mis = 1; m_bad = tgt; m_mode = M_FLUSH;
                    end else begin
                        m_pc = tgt;
                        if (bus.redirect_kind_i == 2'd1) begin
                            m_ras.push_back(bus.redirect_link_i);
                            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                        end else if (bus.redirect_kind_i == 2'd2) begin
                            if (m_ras.size() > 0) void'(m_ras.pop_back());
                            else m_miss = 1;
                        end
                    end
                end else if (fetch) begin
                    m_pc = m_pc + 32'd4;
                end
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.pc_o, 32'h0); end
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.imem_req_o); end
        checks++; if (bus.misalign_o !== 1'b0 || bus.ras_miss_o !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b expected 00", bus.misalign_o, bus.ras_miss_o); end
        checks++; if (bus.badaddr_o !== 32'h0) begin errors++; $display("FAIL reset_badaddr: got %h expected 0", bus.badaddr_o); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL boot_idle: got %b expected 0", bus.imem_req_o); end
        step();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.pc_o !== 32'(4 * i) || bus.imem_req_o !== 1'b1) begin errors++; $display("FAIL seq_fetch%0d: got pc %h req %b expected pc %h req 1", i, bus.pc_o, bus.imem_req_o, 32'(4 * i)); end
            step();
        end
    endtask

    task automatic test_stall();
        drive(0, 1, 1, 2'd0, 32'h8, 32'h0, 0);
        step();
        drive(1, 1, 0, 2'd0, 32'h0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.pc_o !== 32'h8 || bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_hold%0d: got pc %h req %b expected pc 8 req 0", i, bus.pc_o, bus.imem_req_o); end
            step();
        end
        idle();
        #1;
        checks++; if (bus.pc_o !== 32'h8 || bus.imem_req_o !== 1'b1) begin errors++; $display("FAIL stall_release: got pc %h req %b expected pc 8 req 1", bus.pc_o, bus.imem_req_o); end
        step();
        checks++; if (bus.pc_o !== 32'hC) begin errors++; $display("FAIL stall_next: got %h expected c", bus.pc_o); end
        drive(0, 0, 0, 2'd0, 32'h0, 32'h0, 0);
        step();
        step();
        checks++; if (bus.pc_o !== 32'hC || bus.imem_req_o !== 1'b1) begin errors++; $display("FAIL notready_hold: got pc %h req %b expected pc c req 1", bus.pc_o, bus.imem_req_o); end
        idle();
    endtask

    task automatic test_call_ret();
        drive(0, 1, 1, 2'd1, 32'h40, 32'h14, 0);
        step();
        checks++; if (bus.pc_o !== 32'h40) begin errors++; $display("FAIL call_pc: got %h expected 40", bus.pc_o); end
        drive(0, 1, 1, 2'd2, 32'h200, 32'h0, 0);
        step();
        checks++; if (bus.pc_o !== 32'h14 || bus.ras_miss_o !== 1'b0) begin errors++; $display("FAIL ret_pc: got pc %h miss %b expected pc 14 miss 0", bus.pc_o, bus.ras_miss_o); end
        drive(0, 1, 1, 2'd2, 32'h80, 32'h0, 0);
        step();
        checks++; if (bus.pc_o !== 32'h80 || bus.ras_miss_o !== 1'b1) begin errors++; $display("FAIL ret_empty: got pc %h miss %b expected pc 80 miss 1", bus.pc_o, bus.ras_miss_o); end
        idle();
        step();
        checks++; if (bus.ras_miss_o !== 1'b0) begin errors++; $display("FAIL ret_miss_pulse: got %b expected 0", bus.ras_miss_o); end
    endtask

    task automatic test_misalign();
        drive(0, 1, 1, 2'd0, 32'h42, 32'h0, 0);
        step();
        idle();
        #1;
        checks++; if (bus.pc_o !== TRAP || bus.misalign_o !== 1'b1 || bus.badaddr_o !== 32'h42) begin errors++; $display("FAIL misalign_trap: got pc %h mis %b bad %h expected pc 100 mis 1 bad 42", bus.pc_o, bus.misalign_o, bus.badaddr_o); end
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL misalign_flush: got req %b expected 0", bus.imem_req_o); end
        step();
        checks++; if (bus.pc_o !== TRAP || bus.imem_req_o !== 1'b1 || bus.misalign_o !== 1'b0 || bus.badaddr_o !== 32'h42) begin errors++; $display("FAIL misalign_resume: got pc %h req %b mis %b bad %h expected pc 100 req 1 mis 0 bad 42", bus.pc_o, bus.imem_req_o, bus.misalign_o, bus.badaddr_o); end
        step();
        checks++; if (bus.pc_o !== 32'h104) begin errors++; $display("FAIL misalign_fetch: got %h expected 104", bus.pc_o); end
    endtask

    task automatic test_trap_call();
        drive(0, 1, 1, 2'd1, 32'h40, 32'h30, 1);
        step();
        idle();
        #1;
        checks++; if (bus.pc_o !== TRAP || bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL trap_call_pc: got pc %h req %b expected pc 100 req 0", bus.pc_o, bus.imem_req_o); end
        step();
        drive(0, 1, 1, 2'd2, 32'h88, 32'h0, 0);
        step();
        checks++; if (bus.pc_o !== 32'h88 || bus.ras_miss_o !== 1'b1) begin errors++; $display("FAIL trap_no_push: got pc %h miss %b expected pc 88 miss 1", bus.pc_o, bus.ras_miss_o); end
        idle();
        step();
    endtask

    task automatic test_ras_overflow();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, 2'd1, 32'h2000 + 32'(16 * i), 32'h1000 + 32'(4 * i), 0);
            step();
        end
        for (int i = 4; i >= 1; i--) begin
            drive(0, 1, 1, 2'd2, 32'h3000, 32'h0, 0);
            step();
            checks++; if (bus.pc_o !== 32'h1000 + 32'(4 * i) || bus.ras_miss_o !== 1'b0) begin errors++; $display("FAIL ras_pop%0d: got pc %h miss %b expected pc %h miss 0", i, bus.pc_o, bus.ras_miss_o, 32'h1000 + 32'(4 * i)); end
        end
        step();
        checks++; if (bus.pc_o !== 32'h3000 || bus.ras_miss_o !== 1'b1) begin errors++; $display("FAIL ras_drained: got pc %h miss %b expected pc 3000 miss 1", bus.pc_o, bus.ras_miss_o); end
        idle();
        step();
    endtask

    task automatic test_wrap();
        drive(0, 1, 1, 2'd0, 32'hFFFF_FFFC, 32'h0, 0);
        step();
        idle();
        checks++; if (bus.pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup: got %h expected fffffffc", bus.pc_o); end
        step();
        checks++; if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", bus.pc_o); end
    endtask

    task automatic test_random();
        logic [31:0] a, l;
        for (int n = 0; n < 400; n++) begin
            a = $urandom();
            l = $urandom();
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 4) != 0) l[1:0] = 2'b00;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  2'($urandom_range(0, 3)), a, l, $urandom_range(0, 19) == 0);
            step();
            checks++;
            if (bus.pc_o !== m_pc || bus.imem_req_o !== ((m_mode == M_RUN) && !bus.stall_i) ||
                bus.misalign_o !== m_mis || bus.badaddr_o !== m_bad || bus.ras_miss_o !== m_miss) begin
                errors++;
                $display("FAIL random%0d: got pc %h req %b mis %b bad %h miss %b expected pc %h req %b mis %b bad %h miss %b",
                         n, bus.pc_o, bus.imem_req_o, bus.misalign_o, bus.badaddr_o, bus.ras_miss_o,
                         m_pc, (m_mode == M_RUN) && !bus.stall_i, m_mis, m_bad, m_miss);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        step();
        step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.pc_o !== 32'h0 || bus.imem_req_o !== 1'b0 || bus.badaddr_o !== 32'h0) begin errors++; $display("FAIL midreset: got pc %h req %b bad %h expected pc 0 req 0 bad 0", bus.pc_o, bus.imem_req_o, bus.badaddr_o); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL midreset_boot: got req %b expected 0", bus.imem_req_o); end
        step();
        checks++; if (bus.pc_o !== 32'h0 || bus.imem_req_o !== 1'b1) begin errors++; $display("FAIL midreset_first: got pc %h req %b expected pc 0 req 1", bus.pc_o, bus.imem_req_o); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_call_ret();
        test_misalign();
        test_trap_call();
        test_ras_overflow();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
